// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-side signal bundle for mem_access_arbiter.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface mem_access_arbiter_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_ready;
   logic                  inst_valid;
   logic [31:0]           inst_rdata;

   logic                  data_req;
   logic                  data_wen;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [31:0]           data_wdata;
   logic                  data_ready;
   logic                  data_valid;
   logic [31:0]           data_rdata;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ren;
   logic                  mem_wen;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   logic                  busy;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wen, data_addr, data_wdata,
      input  mem_rdata,
      output inst_ready, inst_valid, inst_rdata,
      output data_ready, data_valid, data_rdata,
      output mem_addr, mem_ren, mem_wen, mem_wdata,
      output busy
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wen, data_addr, data_wdata,
      output mem_rdata,
      input  inst_ready, inst_valid, inst_rdata,
      input  data_ready, data_valid, data_rdata,
      input  mem_addr, mem_ren, mem_wen, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between instruction
// fetch and load/store, with a programmable number of wait states per access.
module mem_access_arbiter #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_access_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   state_t                state, state_nxt;
   owner_t                owner, last_owner;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0] addr_l;
   logic [31:0]           wdata_l;
   logic                  wen_l;
   logic [31:0]           rdata_r;

   logic                  grant_inst, grant_data, accept, cnt_zero;
   logic                  inst_ready, data_ready, inst_valid, data_valid;
   logic                  mem_ren, mem_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   // On a tie the requester that did not win the previous accept goes first.
   assign grant_data = bus.data_req & (~bus.inst_req | (last_owner == OWN_INST));
   assign grant_inst = bus.inst_req & ~grant_data;
   assign cnt_zero   = (cnt == '0);
   assign accept     = inst_ready | data_ready;

   always_comb begin
      state_nxt  = state;
      inst_ready = 1'b0;
      data_ready = 1'b0;
      inst_valid = 1'b0;
      data_valid = 1'b0;
      mem_addr   = '0;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            inst_ready = grant_inst & ~rst;
            data_ready = grant_data & ~rst;
            if (inst_ready | data_ready) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_addr  = addr_l;
            mem_ren   = ~wen_l;
            mem_wen   = wen_l & cnt_zero;
            mem_wdata = wdata_l;
            if (cnt_zero) state_nxt = RESP;
         end
         RESP: begin
            inst_valid = (owner == OWN_INST);
            data_valid = (owner == OWN_DATA);
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A reset cycle must never touch memory, even mid-store.
      if (rst) begin
         mem_ren = 1'b0;
         mem_wen = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_INST;
         last_owner <= OWN_DATA;
         cnt        <= '0;
         addr_l     <= '0;
         wdata_l    <= '0;
         wen_l      <= 1'b0;
         rdata_r    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner      <= grant_data ? OWN_DATA : OWN_INST;
            last_owner <= grant_data ? OWN_DATA : OWN_INST;
            addr_l     <= grant_data ? bus.data_addr : bus.inst_addr;
            wen_l      <= grant_data & bus.data_wen;
            wdata_l    <= grant_data ? bus.data_wdata : '0;
            cnt        <= CNT_WIDTH'(WAIT_CYCLES);
         end else if (state == ACCESS) begin
            if (!cnt_zero) cnt <= cnt - CNT_WIDTH'(1);
            else           rdata_r <= wen_l ? '0 : bus.mem_rdata;
         end
      end
   end

   assign bus.inst_ready = inst_ready;
   assign bus.data_ready = data_ready;
   assign bus.inst_valid = inst_valid;
   assign bus.data_valid = data_valid;
   assign bus.inst_rdata = rdata_r;
   assign bus.data_rdata = rdata_r;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_ren    = mem_ren;
   assign bus.mem_wen    = mem_wen;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: three instances (0, 1 and 3 wait states) with
// behavioural memories, checked against a word-array reference model.
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  mem_access_arbiter_if #(.ADDR_WIDTH(10)) b0 ();
  mem_access_arbiter_if #(.ADDR_WIDTH(10)) b1 ();
  mem_access_arbiter_if #(.ADDR_WIDTH(10)) b3 ();

  mem_access_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .CNT_WIDTH(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mem_access_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .CNT_WIDTH(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_access_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .CNT_WIDTH(4)) u3 (.clk(clk), .rst(rst), .bus(b3));

  // requester stimulus, routed only to the selected instance
  int          sel = 0;
  logic        t_inst_req, t_data_req, t_data_wen;
  logic [9:0]  t_inst_addr, t_data_addr;
  logic [31:0] t_data_wdata;

  assign b0.inst_req = (sel == 0) && t_inst_req;
  assign b1.inst_req = (sel == 1) && t_inst_req;
  assign b3.inst_req = (sel == 2) && t_inst_req;
  assign b0.data_req = (sel == 0) && t_data_req;
  assign b1.data_req = (sel == 1) && t_data_req;
  assign b3.data_req = (sel == 2) && t_data_req;
  assign b0.inst_addr = t_inst_addr;   assign b1.inst_addr = t_inst_addr;   assign b3.inst_addr = t_inst_addr;
  assign b0.data_addr = t_data_addr;   assign b1.data_addr = t_data_addr;   assign b3.data_addr = t_data_addr;
  assign b0.data_wen = t_data_wen;     assign b1.data_wen = t_data_wen;     assign b3.data_wen = t_data_wen;
  assign b0.data_wdata = t_data_wdata; assign b1.data_wdata = t_data_wdata; assign b3.data_wdata = t_data_wdata;

  // behavioural single-port memories, asynchronous read, write on clock edge
  logic        pre = 1'b1;
  logic [9:0]  pa = '0;
  logic [31:0] m0 [0:1023];
  logic [31:0] m1 [0:1023];
  logic [31:0] m3 [0:1023];
  assign b0.mem_rdata = m0[b0.mem_addr];
  assign b1.mem_rdata = m1[b1.mem_addr];
  assign b3.mem_rdata = m3[b3.mem_addr];
  always @(posedge clk) begin
    if (pre) m0[pa] <= 32'h0800_0000 | 32'(pa);
    else if (b0.mem_wen) m0[b0.mem_addr] <= b0.mem_wdata;
  end
  always @(posedge clk) begin
    if (pre) m1[pa] <= 32'h0800_0000 | 32'(pa);
    else if (b1.mem_wen) m1[b1.mem_addr] <= b1.mem_wdata;
  end
  always @(posedge clk) begin
    if (pre) m3[pa] <= 32'h0800_0000 | 32'(pa);
    else if (b3.mem_wen) m3[b3.mem_addr] <= b3.mem_wdata;
  end

  typedef struct packed {
    logic ir; logic iv; logic [31:0] ird;
    logic dr; logic dv; logic [31:0] drd;
    logic [9:0] ma; logic mr; logic mw; logic [31:0] mwd; logic bz;
  } obs_t;
  obs_t ob0, ob1, ob3, o;
  assign ob0 = {b0.inst_ready, b0.inst_valid, b0.inst_rdata, b0.data_ready, b0.data_valid, b0.data_rdata,
                b0.mem_addr, b0.mem_ren, b0.mem_wen, b0.mem_wdata, b0.busy};
  assign ob1 = {b1.inst_ready, b1.inst_valid, b1.inst_rdata, b1.data_ready, b1.data_valid, b1.data_rdata,
                b1.mem_addr, b1.mem_ren, b1.mem_wen, b1.mem_wdata, b1.busy};
  assign ob3 = {b3.inst_ready, b3.inst_valid, b3.inst_rdata, b3.data_ready, b3.data_valid, b3.data_rdata,
                b3.mem_addr, b3.mem_ren, b3.mem_wen, b3.mem_wdata, b3.busy};
  assign o = (sel == 0) ? ob0 : (sel == 1) ? ob1 : ob3;

  // reference memory contents, one image per instance
  logic [31:0] rm [0:2][0:1023];

  function automatic int wsel(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 3;
  endfunction

  // one complete transaction on the selected instance, checked end to end
  task automatic xact(input bit isd, input bit wen, input logic [9:0] a, input logic [31:0] wd, input string nm);
    logic [31:0] exp_rd, rd;
    int lat, nwen, nren, noth, nbus, w;
    bit acc;
    w = wsel(sel);
    exp_rd = (isd && wen) ? 32'd0 : rm[sel][a];
    if (isd && wen) rm[sel][a] = wd;
    @(negedge clk);
    if (isd) begin
      t_data_req = 1'b1; t_data_wen = wen; t_data_addr = a; t_data_wdata = wd;
    end else begin
      t_inst_req = 1'b1; t_inst_addr = a;
    end
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (isd ? o.dr : o.ir) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!acc) begin bad++; $display("FAIL %s_accept ready=0 required=1", nm); end
    lat = -1; rd = '0; nwen = 0; nren = 0; noth = 0; nbus = 0;
    for (int k = 1; k <= w + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin t_inst_req = 1'b0; t_data_req = 1'b0; end
      #1;
      if (o.mw) nwen++;
      if (o.mr) nren++;
      if ((o.mr || o.mw) && (o.ma !== a || (o.mw && o.mwd !== wd))) nbus++;
      if (isd ? o.dv : o.iv) begin
        if (lat < 0) begin lat = k; rd = isd ? o.drd : o.ird; end
        else noth++;
      end
      if (isd ? o.iv : o.dv) noth++;
    end
    total++;
    if (lat !== w + 2) begin bad++; $display("FAIL %s_latency got=%0d required=%0d", nm, lat, w + 2); end
    total++;
    if (rd !== exp_rd) begin bad++; $display("FAIL %s_rdata got=%h required=%h", nm, rd, exp_rd); end
    total++;
    if (nwen !== (wen ? 1 : 0)) begin bad++; $display("FAIL %s_wen_cycles got=%0d required=%0d", nm, nwen, wen ? 1 : 0); end
    total++;
    if (nren !== (wen ? 0 : w + 1)) begin bad++; $display("FAIL %s_ren_cycles got=%0d required=%0d", nm, nren, wen ? 0 : w + 1); end
    total++;
    if (nbus !== 0 || noth !== 0) begin bad++; $display("FAIL %s_bus bus_err=%0d stray_valid=%0d required=0/0", nm, nbus, noth); end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pa = 10'(i);
    end
    @(negedge clk);
    pre = 1'b0;
    #1;
    total++;
    if (ob0 !== '0) begin bad++; $display("FAIL reset_w0 got=%h required=0", ob0); end
    total++;
    if (ob1 !== '0) begin bad++; $display("FAIL reset_w1 got=%h required=0", ob1); end
    total++;
    if (ob3 !== '0) begin bad++; $display("FAIL reset_w3 got=%h required=0", ob3); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    sel = 1;
    xact(1'b0, 1'b0, 10'd4, 32'd0, "fetch4");
    xact(1'b0, 1'b0, 10'd1023, 32'd0, "fetch_top");
  endtask

  task automatic test_store_load;
    sel = 0;
    xact(1'b1, 1'b1, 10'd3, 32'd0, "st3");
    xact(1'b1, 1'b0, 10'd3, 32'd0, "ld3");
    xact(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, "st5");
    xact(1'b1, 1'b0, 10'd5, 32'd0, "ld5");
    xact(1'b0, 1'b0, 10'd5, 32'd0, "if5");
  endtask

  task automatic test_alternate;
    int nacc, nval, last, both, w;
    bit own;
    bit q[$];
    logic [31:0] got, want;
    sel = 1; w = wsel(sel);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    t_inst_addr = 10'd8; t_data_addr = 10'd9; t_data_wen = 1'b0;
    t_inst_req = 1'b1; t_data_req = 1'b1;
    nacc = 0; nval = 0; last = 0; both = 0;
    for (int c = 0; c < 40 && nval < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (nacc >= 4) begin t_inst_req = 1'b0; t_data_req = 1'b0; end
      end
      #1;
      if (o.ir && o.dr) both++;
      if (o.ir || o.dr) begin
        own = o.dr;
        total++;
        if (own !== nacc[0]) begin bad++; $display("FAIL alt_grant%0d got=%0d required=%0d", nacc, own, nacc[0]); end
        if (nacc > 0) begin
          total++;
          if (cyc - last !== w + 3) begin bad++; $display("FAIL alt_spacing%0d got=%0d required=%0d", nacc, cyc - last, w + 3); end
        end
        last = cyc; nacc++; q.push_back(own);
      end
      if (o.iv || o.dv) begin
        want = (q.size() > 0 && q[0]) ? rm[1][9] : rm[1][8];
        got  = o.dv ? o.drd : o.ird;
        total++;
        if (q.size() == 0 || o.dv !== q[0] || (o.iv && o.dv) || got !== want) begin
          bad++; $display("FAIL alt_resp%0d iv=%0d dv=%0d rdata=%h required_dv=%0d rdata=%h", nval, o.iv, o.dv, got, q.size() > 0 ? q[0] : 1'b0, want);
        end
        if (q.size() > 0) void'(q.pop_front());
        nval++;
      end
    end
    total++;
    if (nval !== 4 || nacc !== 4 || both !== 0) begin
      bad++; $display("FAIL alt_count accepts=%0d valids=%0d dual_ready=%0d required=4/4/0", nacc, nval, both);
    end
    t_inst_req = 1'b0; t_data_req = 1'b0;
  endtask

  task automatic test_withdraw;
    int ndr, ndv, niv, nbus;
    bit acc;
    logic [31:0] rd;
    sel = 1;
    @(negedge clk);
    t_inst_req = 1'b1; t_inst_addr = 10'd20;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o.ir) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    ndr = 0; ndv = 0; niv = 0; nbus = 0; rd = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        t_inst_req = 1'b0; t_data_req = 1'b1; t_data_addr = 10'd30; t_data_wen = 1'b0;
      end
      if (k == 2) t_data_req = 1'b0;
      #1;
      if (o.dr) ndr++;
      if (o.dv) ndv++;
      if (o.iv) begin niv++; rd = o.ird; end
      if ((o.mr || o.mw) && (o.ma !== 10'd20 || niv > 0)) nbus++;
    end
    total++;
    if (!acc || niv !== 1 || rd !== rm[1][20]) begin
      bad++; $display("FAIL wd_fetch accepted=%0d valids=%0d rdata=%h required=1/1/%h", acc, niv, rd, rm[1][20]);
    end
    total++;
    if (ndr !== 0) begin bad++; $display("FAIL wd_ready got=%0d required=0", ndr); end
    total++;
    if (ndv !== 0) begin bad++; $display("FAIL wd_valid got=%0d required=0", ndv); end
    total++;
    if (nbus !== 0) begin bad++; $display("FAIL wd_mem got=%0d required=0", nbus); end
  endtask

  task automatic test_reset_mid_store;
    int ndv;
    bit acc;
    sel = 0;
    @(negedge clk);
    t_data_req = 1'b1; t_data_wen = 1'b1; t_data_addr = 10'd7; t_data_wdata = 32'h1234_5678;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o.dr) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    t_data_req = 1'b0; rst = 1'b1;
    #1;
    total++;
    if (!acc || o.mw !== 1'b0) begin bad++; $display("FAIL rst_wen accepted=%0d mem_wen=%0d required=1/0", acc, o.mw); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (ob0 !== '0) begin bad++; $display("FAIL rst_outputs got=%h required=0", ob0); end
    ndv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (o.dv || o.iv) ndv++;
    end
    total++;
    if (ndv !== 0) begin bad++; $display("FAIL rst_valid got=%0d required=0", ndv); end
    total++;
    if (m0[7] !== rm[0][7]) begin bad++; $display("FAIL rst_mem got=%h required=%h", m0[7], rm[0][7]); end
    xact(1'b1, 1'b0, 10'd7, 32'd0, "rst_ld7");
  endtask

  task automatic test_sweep;
    bit isd;
    logic [9:0] a;
    sel = 2;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      isd = ($urandom_range(0, 1) == 1);
      a = 10'($urandom_range(0, 1023));
      xact(isd, 1'b0, a, 32'd0, isd ? "swp_ld" : "swp_if");
    end
  endtask

  initial begin
    t_inst_req = 1'b0; t_data_req = 1'b0; t_data_wen = 1'b0;
    t_inst_addr = '0; t_data_addr = '0; t_data_wdata = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 1024; i++) rm[s][i] = 32'h0800_0000 | 32'(i);
    test_reset;
    test_single_fetch;
    test_store_load;
    test_alternate;
    test_withdraw;
    test_reset_mid_store;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
